// File: rtl/heater_scheduler.sv
// heater_scheduler: arbitrates one heating element between two dispenser channels.
// Round-robin on ties, minimum on-time, pre-emption at MAX_ON when the other channel
// waits, and a dead-time gap with the heater off between consecutive holders.
module heater_scheduler #(
    parameter int unsigned MIN_ON = 25,
    parameter int unsigned MAX_ON = 50,
    parameter int unsigned GAP    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [1:0] hot_i,
    output logic [1:0] grant_o,
    output logic       heater_on_o,
    output logic [1:0] state_o,
    output logic       preempt_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHeat = 2'b01,
        StGap  = 2'b10
    } state_e;

    localparam logic [16:0] MinOn17 = 17'(MIN_ON);
    localparam logic [16:0] MaxOn17 = 17'(MAX_ON);
    localparam logic [16:0] Gap17   = 17'(GAP);

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        heater_q, heater_d;
    logic        preempt_q, preempt_d;
    logic        ch_q, ch_d;
    logic        last_q, last_d;
    logic [15:0] on_cnt_q, on_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;

    // Release decision terms, evaluated only while heating.
    logic [16:0] on_next;
    logic [16:0] gap_next;
    logic        rel_norm;
    logic        rel_pre;
    logic        pick;

    assign on_next  = {1'b0, on_cnt_q} + 17'd1;
    assign gap_next = {1'b0, gap_cnt_q} + 17'd1;
    assign rel_norm = (on_next >= MinOn17) && (!req_i[ch_q] || hot_i[ch_q]);
    // A normal release takes priority so preempt only flags true forced hand-overs.
    assign rel_pre  = (on_next >= MaxOn17) && req_i[~ch_q] && !rel_norm;
    // On a tie the channel that did not hold last wins.
    assign pick     = (req_i == 2'b11) ? ~last_q : req_i[1];

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        preempt_d = 1'b0;
        ch_d      = ch_q;
        last_d    = last_q;
        on_cnt_d  = on_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                grant_d = 2'b00;
                if (req_i != 2'b00) begin
                    ch_d     = pick;
                    grant_d  = pick ? 2'b10 : 2'b01;
                    on_cnt_d = 16'd0;
                    state_d  = StHeat;
                end
            end
            StHeat: begin
                // Saturate at MAX_ON so a long solo hold never wraps the counter.
                if ({1'b0, on_cnt_q} < MaxOn17) begin
                    on_cnt_d = on_next[15:0];
                end
                if (rel_norm || rel_pre) begin
                    grant_d   = 2'b00;
                    last_d    = ch_q;
                    gap_cnt_d = 16'd0;
                    preempt_d = rel_pre;
                    state_d   = StGap;
                end
            end
            StGap: begin
                grant_d   = 2'b00;
                gap_cnt_d = gap_next[15:0];
                if (gap_next == Gap17) begin
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
        endcase
        heater_d = |grant_d;
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            heater_q  <= 1'b0;
            preempt_q <= 1'b0;
            ch_q      <= 1'b0;
            last_q    <= 1'b1;
            on_cnt_q  <= 16'd0;
            gap_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            heater_q  <= heater_d;
            preempt_q <= preempt_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            on_cnt_q  <= on_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign heater_on_o = heater_q;
    assign state_o     = state_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_heater_scheduler.sv
// tb_heater_scheduler: directed checks of heater_scheduler with default parameters
// (MIN_ON=25, MAX_ON=50, GAP=4).
module tb_heater_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] hot;
    logic [1:0] grant;
    logic       heater_on;
    logic [1:0] state;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    heater_scheduler #(
        .MIN_ON(25),
        .MAX_ON(50),
        .GAP   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .hot_i      (hot),
        .grant_o    (grant),
        .heater_on_o(heater_on),
        .state_o    (state),
        .preempt_o  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive samples (including the current one) with grant == g.
    task automatic count_grant(input logic [1:0] g, output int n);
        n = 0;
        while (grant === g && n < 1000) begin
            n++;
            step();
        end
    endtask

    task automatic count_state(input logic [1:0] s, output int n);
        n = 0;
        while (state === s && n < 1000) begin
            n++;
            step();
        end
    endtask

    // Reset for one edge, leaving the given inputs applied at release.
    task automatic do_reset(input logic [1:0] r, input logic [1:0] h);
        rst = 1'b1;
        req = r;
        hot = h;
        step();
        rst = 1'b0;
    endtask

    int n;
    int m;
    logic seen_pre;
    logic seen_drop;

    initial begin
        rst = 1'b0;
        req = 2'b00;
        hot = 2'b00;
        #2;

        // Reset and single request, hot[0] raised at cycle 3.
        rst = 1'b1;
        req = 2'b01;
        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_heater", heater_on, 0);
        check_eq("rst_state", state, 0);
        check_eq("rst_preempt", preempt, 0);
        step();
        rst = 1'b0;
        step();
        check_eq("t1_grant_first", grant, 1);
        check_eq("t1_heater_on", heater_on, 1);
        check_eq("t1_state_heat", state, 1);
        step();
        step();
        hot = 2'b01;
        step();
        n = 3;
        count_grant(2'b01, m);
        check_eq("t1_on_len", n + m, 25);
        check_eq("t1_state_gap", state, 2);
        check_eq("t1_preempt", preempt, 0);
        check_eq("t1_heater_off", heater_on, 0);
        req = 2'b00;
        hot = 2'b00;
        count_state(2'b10, n);
        check_eq("t1_gap_len", n, 4);
        check_eq("t1_state_idle", state, 0);

        // Tie and pre-empt.
        do_reset(2'b11, 2'b00);
        step();
        check_eq("t2_first_grant", grant, 1);
        count_grant(2'b01, n);
        check_eq("t2_on_len0", n, 50);
        check_eq("t2_preempt0", preempt, 1);
        count_grant(2'b00, n);
        check_eq("t2_off_len0", n, 5);
        check_eq("t2_second_grant", grant, 2);
        check_eq("t2_preempt_low", preempt, 0);
        count_grant(2'b10, n);
        check_eq("t2_on_len1", n, 50);
        check_eq("t2_preempt1", preempt, 1);
        count_grant(2'b00, n);
        check_eq("t2_off_len1", n, 5);
        check_eq("t2_third_grant", grant, 1);

        // No pre-empt without a waiter.
        do_reset(2'b01, 2'b00);
        step();
        seen_pre  = 1'b0;
        seen_drop = 1'b0;
        for (int i = 0; i < 200; i++) begin
            seen_pre  = seen_pre | preempt;
            seen_drop = seen_drop | (grant !== 2'b01);
            step();
        end
        check_eq("t3_grant_held", grant, 1);
        check_eq("t3_no_preempt", seen_pre, 0);
        check_eq("t3_no_drop", seen_drop, 0);

        // Minimum on-time: req[1] drops at cycle 5 of the grant.
        do_reset(2'b10, 2'b00);
        step();
        check_eq("t4_grant", grant, 2);
        n = 0;
        while (grant === 2'b10 && n < 1000) begin
            n++;
            if (n == 5) req = 2'b00;
            step();
        end
        check_eq("t4_on_len", n, 25);
        check_eq("t4_preempt", preempt, 0);
        check_eq("t4_state_gap", state, 2);

        // Reset mid-HEAT: last is 0 beforehand, so only reset makes channel 0 win.
        do_reset(2'b01, 2'b01);
        step();
        count_grant(2'b01, n);
        check_eq("t5_ch0_len", n, 25);
        req = 2'b10;
        hot = 2'b00;
        count_grant(2'b00, n);
        check_eq("t5_ch1_grant", grant, 2);
        for (int i = 0; i < 10; i++) step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_async_grant", grant, 0);
        check_eq("t5_async_heater", heater_on, 0);
        check_eq("t5_async_state", state, 0);
        req = 2'b11;
        step();
        rst = 1'b0;
        step();
        check_eq("t5_after_rst_grant", grant, 1);

        // Request during GAP: req[1] rises at the second GAP cycle.
        do_reset(2'b01, 2'b01);
        step();
        count_grant(2'b01, n);
        check_eq("t6_on_len", n, 25);
        req = 2'b00;
        hot = 2'b00;
        step();
        req = 2'b10;
        count_grant(2'b00, m);
        check_eq("t6_off_len", 1 + m, 5);
        check_eq("t6_grant_ch1", grant, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
